// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling driven by a bit-period
// counter, and one-cycle valid / framing-error pulses.
module uart_receiver #(
    parameter int CYCLES_PER_BIT = 697394,
    parameter int COUNT_WIDTH    = 24
) (
    input  logic       clk,
    input  logic       r_reset,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_framing_error,
    output logic       o_busy
);

    localparam int HALF = CYCLES_PER_BIT / 2;
    localparam logic [COUNT_WIDTH-1:0] LAST_CNT = COUNT_WIDTH'(CYCLES_PER_BIT - 1);
    localparam logic [COUNT_WIDTH-1:0] HALF_CNT = COUNT_WIDTH'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t                 state_reg;
    logic [COUNT_WIDTH-1:0] counter_reg;
    logic [2:0]             bit_idx_reg;
    logic                   sync1_reg;
    logic                   rx_s;
    logic [7:0]             shift_reg;
    logic [7:0]             shift_next;
    logic                   sample_data;

    assign sample_data = (state_reg == DATA) && (counter_reg == LAST_CNT);

    // Each shift-register bit only loads on the mid-bit sample addressed to it.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shift
            assign shift_next[gi] = (sample_data && (bit_idx_reg == 3'(gi))) ? rx_s : shift_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (r_reset) begin
            shift_reg <= 8'h00;
        end else begin
            shift_reg <= shift_next;
        end
    end

    always_ff @(posedge clk) begin
        if (r_reset) begin
            sync1_reg       <= 1'b1;
            rx_s            <= 1'b1;
            state_reg       <= IDLE;
            counter_reg     <= '0;
            bit_idx_reg     <= 3'd0;
            o_data          <= 8'h00;
            o_valid         <= 1'b0;
            o_framing_error <= 1'b0;
            o_busy          <= 1'b0;
        end else begin
            sync1_reg       <= i_rx;
            rx_s            <= sync1_reg;
            o_valid         <= 1'b0;
            o_framing_error <= 1'b0;
            case (state_reg)
                IDLE: begin
                    counter_reg <= '0;
                    if (!rx_s) begin
                        state_reg <= START;
                        o_busy    <= 1'b1;
                    end
                end
                START: begin
                    if (counter_reg == HALF_CNT) begin
                        counter_reg <= '0;
                        if (!rx_s) begin
                            state_reg   <= DATA;
                            bit_idx_reg <= 3'd0;
                        end else begin
                            // Start bit did not survive to mid-bit: treat as line noise.
                            state_reg <= IDLE;
                            o_busy    <= 1'b0;
                        end
                    end else begin
                        counter_reg <= counter_reg + COUNT_WIDTH'(1);
                    end
                end
                DATA: begin
                    if (counter_reg == LAST_CNT) begin
                        counter_reg <= '0;
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= STOP;
                        end
                    end else begin
                        counter_reg <= counter_reg + COUNT_WIDTH'(1);
                    end
                end
                STOP: begin
                    if (counter_reg == LAST_CNT) begin
                        counter_reg <= '0;
                        if (rx_s) begin
                            o_data    <= shift_reg;
                            o_valid   <= 1'b1;
                            state_reg <= IDLE;
                            o_busy    <= 1'b0;
                        end else begin
                            o_framing_error <= 1'b1;
                            state_reg       <= BREAK;
                        end
                    end else begin
                        counter_reg <= counter_reg + COUNT_WIDTH'(1);
                    end
                end
                BREAK: begin
                    // Wait for the line to recover so a held-low line cannot re-trigger.
                    counter_reg <= '0;
                    if (rx_s) begin
                        state_reg <= IDLE;
                        o_busy    <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    counter_reg <= '0;
                    o_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
